regs_writeback: RTL and testbench

Write-back stage of the DLX pipeline: it drives the register file's single write port. It merges single-cycle ALU results with load results that arrive from the memory stage through a valid/ready handshake, and buffers loads in a small FIFO. It keeps a scoreboard of destination registers with pending writes, so decode can detect RAW hazards. Its outputs connect directly to the register file's `Rd`/`reg_in` inputs.

---
 rtl/regs_writeback_if.sv | 35 +++
 rtl/regs_writeback.sv | 83 ++++++++
 tb/tb_regs_writeback.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regs_writeback_if.sv
// Write-back stage port bundle: ALU result, load handshake, issue notify and
// register-file write port plus scoreboard/occupancy status.
interface regs_writeback_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic [4:0]    Rd;
  logic [31:0]   reg_in;
  logic [31:0]   busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  mem_ready, Rd, reg_in, busy, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output mem_ready, Rd, reg_in, busy, fifo_count
  );
endinterface

// File: rtl/regs_writeback.sv
// DLX write-back stage: ALU results take priority over buffered load results,
// and a scoreboard tracks destination registers with writes still pending.
module regs_writeback #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset_n,
  regs_writeback_if.slave wb
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]    fifo_rd_mem   [DEPTH];
  logic [31:0]   fifo_data_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_reg, ready_next;
  logic [4:0]    rd_reg, rd_next;
  logic [31:0]   data_reg, data_next;
  logic [31:0]   busy_reg, busy_next;

  logic          alu_sel, pop, push, wr_en;
  logic [4:0]    wr_rd;
  logic [31:0]   wr_data;

  always_comb begin
    alu_sel    = wb.alu_valid && (wb.alu_rd != 5'd0);
    pop        = !alu_sel && (count_reg != '0);
    // Loads to r0 are accepted (handshake completes) but never stored.
    push       = wb.mem_valid && ready_reg && (wb.mem_rd != 5'd0);
    wr_en      = alu_sel || pop;
    wr_rd      = alu_sel ? wb.alu_rd   : fifo_rd_mem[rd_ptr_reg];
    wr_data    = alu_sel ? wb.alu_data : fifo_data_mem[rd_ptr_reg];
    rd_next    = wr_en ? wr_rd   : 5'd0;
    data_next  = wr_en ? wr_data : 32'd0;
    count_next = count_reg + CW'(push) - CW'(pop);
    ready_next = (count_next < DEPTH_C);
  end

  // Set from issue beats the clear from a write to the same register.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (wb.issue_valid && (wb.issue_rd == 5'(gi))) ||
                             (busy_reg[gi] && !(wr_en && (wr_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
      rd_reg     <= 5'd0;
      data_reg   <= 32'd0;
      busy_reg   <= 32'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ready_reg <= ready_next;
      rd_reg    <= rd_next;
      data_reg  <= data_next;
      busy_reg  <= busy_next;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_mem[wr_ptr_reg]   <= wb.mem_rd;
      fifo_data_mem[wr_ptr_reg] <= wb.mem_data;
    end
  end

  assign wb.mem_ready  = ready_reg;
  assign wb.Rd         = rd_reg;
  assign wb.reg_in     = data_reg;
  assign wb.busy       = busy_reg;
  assign wb.fifo_count = count_reg;
endmodule

// File: tb/tb_regs_writeback.sv
// Directed vector bench for regs_writeback: table of per-cycle stimulus and
// expected outputs, plus hand-written reset sequences.
module tb_regs_writeback;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  regs_writeback_if #(.DEPTH(4)) wb ();
  regs_writeback #(.DEPTH(4)) dut (.clk(clk), .reset_n(reset_n), .wb(wb));

  always #5 clk = ~clk;

  typedef struct {
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  exp_rd;
    logic [31:0] exp_reg;
    logic [31:0] exp_busy;
    logic [2:0]  exp_cnt;
    logic        exp_rdy;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] erd, input logic [31:0] ereg,
                              input logic [31:0] ebusy, input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.alu_valid = av;  v.alu_rd = ard;  v.alu_data = ad;
    v.mem_valid = mv;  v.mem_rd = mrd;  v.mem_data = md;
    v.issue_valid = iv; v.issue_rd = ird;
    v.exp_rd = erd; v.exp_reg = ereg; v.exp_busy = ebusy; v.exp_cnt = ecnt; v.exp_rdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wb.alu_valid = 1'b0; wb.alu_rd = 5'd0; wb.alu_data = 32'd0;
    wb.mem_valid = 1'b0; wb.mem_rd = 5'd0; wb.mem_data = 32'd0;
    wb.issue_valid = 1'b0; wb.issue_rd = 5'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [4:0] erd, input logic [31:0] ereg,
                         input logic [31:0] ebusy, input logic [2:0] ecnt, input logic erdy);
    chk({tag, ".Rd"},         32'(wb.Rd),         32'(erd));
    chk({tag, ".reg_in"},     wb.reg_in,          ereg);
    chk({tag, ".busy"},       wb.busy,            ebusy);
    chk({tag, ".fifo_count"}, 32'(wb.fifo_count), 32'(ecnt));
    chk({tag, ".mem_ready"},  32'(wb.mem_ready),  32'(erdy));
  endtask

  initial begin
    // av rd data | mv rd data | iv rd || exp Rd reg busy cnt rdy
    tbl[0]  = mk(0,0,0,          0,0,0,           1,5,  0,0,32'h0020,0,1);
    tbl[1]  = mk(0,0,0,          0,0,0,           0,0,  0,0,32'h0020,0,1);
    tbl[2]  = mk(1,5,32'h1234,   0,0,0,           0,0,  5,32'h1234,0,0,1);
    tbl[3]  = mk(0,0,0,          0,0,0,           0,0,  0,0,0,0,1);
    tbl[4]  = mk(1,7,32'h70,     1,1,32'hA1,      0,0,  7,32'h70,0,1,1);
    tbl[5]  = mk(1,7,32'h71,     1,2,32'hA2,      0,0,  7,32'h71,0,2,1);
    tbl[6]  = mk(1,7,32'h72,     1,3,32'hA3,      0,0,  7,32'h72,0,3,1);
    tbl[7]  = mk(1,7,32'h73,     1,4,32'hA4,      0,0,  7,32'h73,0,4,0);
    tbl[8]  = mk(1,7,32'h74,     1,5,32'hA5,      0,0,  7,32'h74,0,4,0);
    tbl[9]  = mk(1,7,32'h75,     0,0,0,           0,0,  7,32'h75,0,4,0);
    tbl[10] = mk(0,0,0,          0,0,0,           0,0,  1,32'hA1,0,3,1);
    tbl[11] = mk(0,0,0,          0,0,0,           0,0,  2,32'hA2,0,2,1);
    tbl[12] = mk(0,0,0,          0,0,0,           0,0,  3,32'hA3,0,1,1);
    tbl[13] = mk(0,0,0,          0,0,0,           0,0,  4,32'hA4,0,0,1);
    tbl[14] = mk(0,0,0,          0,0,0,           0,0,  0,0,0,0,1);
    tbl[15] = mk(0,0,0,          1,9,32'h22,      0,0,  0,0,0,1,1);
    tbl[16] = mk(1,3,32'h11,     0,0,0,           0,0,  3,32'h11,0,1,1);
    tbl[17] = mk(1,0,32'h55,     0,0,0,           0,0,  9,32'h22,0,0,1);
    tbl[18] = mk(0,0,0,          0,0,0,           0,0,  0,0,0,0,1);
    tbl[19] = mk(0,0,0,          0,0,0,           1,6,  0,0,32'h0040,0,1);
    tbl[20] = mk(1,6,32'h66,     0,0,0,           1,6,  6,32'h66,32'h0040,0,1);
    tbl[21] = mk(1,6,32'h67,     0,0,0,           0,0,  6,32'h67,0,0,1);
    tbl[22] = mk(0,0,0,          1,0,32'hDEAD,    0,0,  0,0,0,0,1);
    tbl[23] = mk(0,0,0,          0,0,0,           0,0,  0,0,0,0,1);
    tbl[24] = mk(0,0,0,          0,0,0,           1,0,  0,0,0,0,1);
    tbl[25] = mk(0,0,0,          1,10,32'hB0,     1,10, 0,0,32'h0400,1,1);
    tbl[26] = mk(0,0,0,          1,11,32'hB1,     0,0,  10,32'hB0,0,1,1);
    tbl[27] = mk(0,0,0,          0,0,0,           0,0,  11,32'hB1,0,0,1);
    tbl[28] = mk(0,0,0,          0,0,0,           0,0,  0,0,0,0,1);

    drive_idle();
    reset_n = 1'b0;
    step();
    step();
    chk_all("in_reset", 5'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    reset_n = 1'b1;
    step();
    chk_all("after_release", 5'd0, 32'd0, 32'd0, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 5'd0, 32'd0, 32'd0, 3'd0, 1'b1);
    end

    for (int i = 0; i < NV; i++) begin
      wb.alu_valid = tbl[i].alu_valid; wb.alu_rd = tbl[i].alu_rd; wb.alu_data = tbl[i].alu_data;
      wb.mem_valid = tbl[i].mem_valid; wb.mem_rd = tbl[i].mem_rd; wb.mem_data = tbl[i].mem_data;
      wb.issue_valid = tbl[i].issue_valid; wb.issue_rd = tbl[i].issue_rd;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].exp_rd, tbl[i].exp_reg,
              tbl[i].exp_busy, tbl[i].exp_cnt, tbl[i].exp_rdy);
      $display("vec %0d: Rd=%0d reg_in=0x%0h busy=0x%0h count=%0d ready=%0b",
               i, wb.Rd, wb.reg_in, wb.busy, wb.fifo_count, wb.mem_ready);
    end

    // Reset mid-burst: three loads held behind ALU writes, r8 pending.
    for (int i = 0; i < 3; i++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h80 + 32'(i);
      wb.mem_valid = 1'b1; wb.mem_rd = 5'(i + 1); wb.mem_data = 32'hC0 + 32'(i);
      wb.issue_valid = (i == 0); wb.issue_rd = 5'd8;
      step();
    end
    chk_all("pre_reset", 5'd7, 32'h82, 32'h0100, 3'd3, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 5'd0, 32'd0, 32'd0, 3'd0, 1'b0);
    drive_idle();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("post_reset%0d", i), 5'd0, 32'd0, 32'd0, 3'd0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
